// File: rtl/cmt_pkg.sv
// Shared types and helpers for the cmt input path (buffer and shim).
package cmt_pkg;

    typedef enum logic {STREAM, DONE} cmt_buf_state_t;

    function automatic int cmt_frame_words(int n);
        return n * n + n * n * n;
    endfunction

endpackage

// File: rtl/cmt_fifo_mem.sv
// Storage array for the input buffer: one synchronous write port, one async read port.
module cmt_fifo_mem #(
    parameter int width = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [width-1:0] rdata
);

    // Array is deliberately left unreset; occupancy tracking lives in the top.
    logic [width-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cmt_input_buffer.sv
// Elastic DMA-to-shim buffer with per-frame metering.
// Optional occupancy output enabled by defining CMT_IN_BUF_LEVEL_EN.
module cmt_input_buffer
    import cmt_pkg::*;
#(
    parameter int width = 32,
    parameter int N     = 4,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [width-1:0]         wr_data,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic                     stall,
    input  logic                     frame_clr,
    output logic [width-1:0]         rd_data,
    output logic                     rd_vld,
    output logic                     frame_done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int FRAME_WORDS = cmt_frame_words(N);
    localparam int AW          = $clog2(DEPTH);
    localparam int CW          = AW + 1;
    localparam int FW          = $clog2(FRAME_WORDS) + 1;

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [FW-1:0]    f_cnt;
    logic             rdy_q;
    logic             push, pop, empty, full;
    logic [width-1:0] mem_rdata;
    cmt_buf_state_t   state, state_nxt;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    // Full is judged on the registered count only, so a same-cycle pop never reopens wr_rdy.
    assign wr_rdy = rdy_q && !full;
    assign push   = wr_vld && wr_rdy;

    always_comb begin
        pop       = 1'b0;
        state_nxt = state;
        case (state)
            STREAM: begin
                pop = !empty && !stall;
                if (!frame_clr && pop && f_cnt == FW'(FRAME_WORDS - 1)) state_nxt = DONE;
            end
            DONE: begin
                if (frame_clr) state_nxt = STREAM;
            end
            default: state_nxt = STREAM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STREAM;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A clear wins over a same-cycle pop: the word goes out but starts no new frame count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_cnt      <= '0;
            frame_done <= 1'b0;
        end else begin
            if (frame_clr) f_cnt <= '0;
            else if (pop)  f_cnt <= f_cnt + FW'(1);
            frame_done <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= pop;
            if (pop) rd_data <= mem_rdata;
        end
    end

    cmt_fifo_mem #(
        .width (width),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

`ifdef CMT_IN_BUF_LEVEL_EN
    assign level = count;
`else
    assign level = '0;
`endif

endmodule

// File: tb/tb_cmt_input_buffer.sv
// Scoreboard bench for cmt_input_buffer: directed phases plus a randomized soak.
module tb_cmt_input_buffer;

    localparam int W     = 32;
    localparam int NN    = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = NN * NN + NN * NN * NN;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [W-1:0]          wr_data;
    logic                  wr_vld;
    logic                  wr_rdy;
    logic                  stall;
    logic                  frame_clr;
    logic [W-1:0]          rd_data;
    logic                  rd_vld;
    logic                  frame_done;
    logic [$clog2(DEPTH):0] level;

    cmt_input_buffer #(.width(W), .N(NN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_data    (wr_data),
        .wr_vld     (wr_vld),
        .wr_rdy     (wr_rdy),
        .stall      (stall),
        .frame_clr  (frame_clr),
        .rd_data    (rd_data),
        .rd_vld     (rd_vld),
        .frame_done (frame_done),
        .level      (level)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int rx_cnt = 0;
    bit started = 0;

    // Reference model: exp_q holds every accepted word not yet seen at the output,
    // so its size is the buffer occupancy at each rising edge.
    logic [W-1:0] exp_q[$];
    bit m_vld = 0;
    bit m_done = 0;
    bit m_rdy = 0;
    int m_fcnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, want, want, $time);
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit po, pu;
        int sz;
        if (!rst_n) begin
            exp_q.delete();
            m_vld  = 0;
            m_done = 0;
            m_fcnt = 0;
            m_rdy  = 0;
        end else begin
            sz = exp_q.size();
            po = !m_done && sz > 0 && !stall;
            pu = wr_vld && m_rdy && sz < DEPTH;
            m_vld = po;
            if (pu) exp_q.push_back(wr_data);
            if (frame_clr) begin
                m_fcnt = 0;
                m_done = 0;
            end else if (po) begin
                m_fcnt++;
                if (m_fcnt == FRAME) m_done = 1;
            end
            m_rdy = 1;
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] want;
        if (started) begin
            if (rd_vld) begin
                rx_cnt++;
                if (exp_q.size() == 0) fail_now("rd_unexpected");
                else begin
                    want = exp_q.pop_front();
                    chk("rd_data", rd_data, want);
                end
            end
            chk("rd_vld", rd_vld, m_vld);
            chk("wr_rdy", wr_rdy, m_rdy && exp_q.size() < DEPTH);
            chk("frame_done", frame_done, m_done);
`ifdef CMT_IN_BUF_LEVEL_EN
            chk("level", level, exp_q.size());
`else
            chk("level", level, 0);
`endif
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        frame_clr = 1;
        step();
        frame_clr = 0;
    endtask

    // mode 0: stall low, 1: stall toggles every cycle, 2: stall held high
    task automatic write_words(input int n, input int base, input int mode);
        int acc = 0;
        int k = 0;
        bit a;
        while (acc < n && k < 2000) begin
            wr_vld  = 1;
            wr_data = base + acc;
            stall   = (mode == 1) ? (k % 2 == 1) : (mode == 2);
            a = wr_rdy;
            step();
            if (a) acc++;
            k++;
        end
        wr_vld = 0;
        if (acc < n) fail_now("write_timeout");
    endtask

    task automatic drain(input int lim);
        int k = 0;
        while (!(m_done || exp_q.size() == 0)) begin
            step();
            k++;
            if (k > lim) begin
                fail_now("drain_timeout");
                break;
            end
        end
    endtask

    initial begin
        int rx0, acc, i, k;
        wr_vld = 0; wr_data = 0; stall = 0; frame_clr = 0; rst_n = 1;
        #1 rst_n = 0;
        started = 1;
        #1;
        chk("reset_rd_vld", rd_vld, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_wr_rdy", wr_rdy, 0);
        repeat (3) step();
        rst_n = 1;

        // back-to-back frame
        rx0 = rx_cnt;
        write_words(FRAME, 0, 0);
        drain(400);
        chk("p1_rx", rx_cnt - rx0, FRAME);
        chk("p1_done", frame_done, 1);

        // fill with no pops; 17th write must bounce
        pulse_clr();
        stall = 1; wr_vld = 1; acc = 0;
        for (int j = 0; j < 17; j++) begin
            wr_data = 100 + j;
            if (wr_rdy) acc++;
            step();
        end
        wr_vld = 0;
        chk("p2_wr_rdy", wr_rdy, 0);
        chk("p2_acc", acc, DEPTH);
`ifdef CMT_IN_BUF_LEVEL_EN
        chk("p2_level", level, DEPTH);
`endif
        stall = 0;
        drain(400);

        // alternating stall
        pulse_clr();
        rx0 = rx_cnt;
        write_words(FRAME, 0, 1);
        stall = 0;
        drain(400);
        chk("p3_rx", rx_cnt - rx0, FRAME);
        chk("p3_done", frame_done, 1);

        // overfill a frame, release the remainder with a clear
        pulse_clr();
        rx0 = rx_cnt;
        write_words(FRAME + 10, 200, 0);
        drain(400);
        chk("p4_rx", rx_cnt - rx0, FRAME);
        chk("p4_done", frame_done, 1);
        rx0 = rx_cnt;
        frame_clr = 1;
        step();
        frame_clr = 0;
        chk("p4_clr_edge_vld", rd_vld, 0);
        step();
        chk("p4_next_vld", rd_vld, 1);
        drain(400);
        chk("p4_rest", rx_cnt - rx0, 10);

        // async reset mid-frame
        pulse_clr();
        rx0 = rx_cnt; i = 0; k = 0;
        while (rx_cnt - rx0 < 37 && k < 300) begin
            wr_vld = 1;
            wr_data = 300 + i;
            if (wr_rdy) i++;
            step();
            k++;
        end
        chk("p5_reached", (rx_cnt - rx0) >= 37, 1);
        #1 rst_n = 0;
        #1;
        chk("p5_rd_vld", rd_vld, 0);
        chk("p5_done", frame_done, 0);
        chk("p5_wr_rdy", wr_rdy, 0);
        chk("p5_level", level, 0);
        wr_vld = 0;
        step(); step();
        rst_n = 1;
        rx0 = rx_cnt;
        write_words(FRAME, 0, 0);
        drain(400);
        chk("p5_rx", rx_cnt - rx0, FRAME);
        chk("p5_done2", frame_done, 1);

        // push+pop at count DEPTH-1, then at count 1
        pulse_clr();
        rx0 = rx_cnt;
        write_words(DEPTH - 1, 400, 2);
        wr_vld = 1; wr_data = 415; stall = 0;
`ifdef CMT_IN_BUF_LEVEL_EN
        chk("p6_level_pre", level, DEPTH - 1);
        step();
        chk("p6_level_post", level, DEPTH - 1);
`else
        step();
`endif
        wr_vld = 0;
        drain(400);
        write_words(6, 500, 0);
        drain(400);
        chk("p6_rx", rx_cnt - rx0, DEPTH + 6);

        // randomized soak
        pulse_clr();
        for (int c = 0; c < 600; c++) begin
            wr_vld    = ($urandom_range(0, 1) == 1);
            wr_data   = $urandom;
            stall     = ($urandom_range(0, 2) == 0);
            frame_clr = ($urandom_range(0, 29) == 0);
            step();
        end
        wr_vld = 0; stall = 0; frame_clr = 0;
        repeat (4) begin
            pulse_clr();
            drain(200);
        end
        chk("final_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
